mandelbrot_frame_engine: RTL and testbench

// - Parametrised escape-time Mandelbrot pixel generator feeding the VGA frame path.
// - On start, scans an H_ACTIVE x V_ACTIVE raster over a programmable complex window (x_min, y_min, step).
// - Iterates z <= z^2 + c per pixel in fixed point, one iteration per clk.
// - Streams one pixel result per valid/ready handshake to the framebuffer writer.

---
 rtl/mandelbrot_frame_engine.sv | 173 +++++++++++++++++
 tb/tb_mandelbrot_frame_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_frame_engine.sv
// Escape-time Mandelbrot raster generator with valid/ready pixel output.
// Define MANDEL_PALETTE_EN for the 16-entry palette; otherwise pixels use a grey ramp.
module mandelbrot_frame_engine #(
  parameter int unsigned H_ACTIVE  = 64,
  parameter int unsigned V_ACTIVE  = 48,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 12,
  parameter int unsigned MAX_ITER  = 64,
  parameter int unsigned ITER_W    = 7,
  localparam int unsigned ADDR_W   = (H_ACTIVE * V_ACTIVE > 1) ? $clog2(H_ACTIVE * V_ACTIVE) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] x_min,
  input  logic signed [DATA_W-1:0] y_min,
  input  logic signed [DATA_W-1:0] step,
  output logic                     busy,
  output logic                     done,
  output logic                     px_valid,
  input  logic                     px_ready,
  output logic [ADDR_W-1:0]        px_addr,
  output logic [ITER_W-1:0]        px_iter,
  output logic [23:0]              px_rgb
);

  localparam int unsigned Z_W = DATA_W + 4;
  localparam int unsigned P_W = 2 * Z_W;
  localparam int unsigned S_W = P_W + 1;
  localparam int unsigned X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic signed [S_W-1:0] ESC_LIM = S_W'(4) <<< (2 * FRAC_BITS);
  localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(H_ACTIVE - 1);

  typedef enum logic [2:0] {StIdle, StInit, StIter, StEmit, StDone} state_e;

  state_e                   r_state;
  logic signed [Z_W-1:0]    r_x_min, r_step, r_c_re, r_c_im, r_zr, r_zi;
  logic [ITER_W-1:0]        r_cnt, r_px_iter;
  logic [X_W-1:0]           r_x;
  logic [ADDR_W-1:0]        r_addr;
  logic [23:0]              r_px_rgb;
  logic                     r_busy, r_done, r_px_valid;

  logic signed [P_W-1:0]    w_zr2, w_zi2, w_zri;
  logic signed [S_W-1:0]    w_mag;
  logic signed [Z_W-1:0]    w_zr_nxt, w_zi_nxt;
  logic                     w_esc;
  logic [ITER_W-1:0]        w_iter_sel;
  logic [23:0]              w_rgb;

  assign w_zr2 = r_zr * r_zr;
  assign w_zi2 = r_zi * r_zi;
  assign w_zri = r_zr * r_zi;
  assign w_mag = S_W'(w_zr2) + S_W'(w_zi2);
  assign w_esc = w_mag > ESC_LIM;
  assign w_zr_nxt = Z_W'((w_zr2 - w_zi2) >>> FRAC_BITS) + r_c_re;
  assign w_zi_nxt = Z_W'((w_zri <<< 1) >>> FRAC_BITS) + r_c_im;
  assign w_iter_sel = w_esc ? r_cnt : ITER_MAX;

`ifdef MANDEL_PALETTE_EN
  logic [3:0] w_pk;
  assign w_pk = w_iter_sel[3:0];

  always_comb begin
    w_rgb = '0;
    if (w_iter_sel != ITER_MAX) begin
      w_rgb = {w_pk, 4'h0, 8'hFF - {w_pk, 4'h0}, 1'b0, w_pk, 3'h0};
    end
  end
`else
  localparam int unsigned G_W = ITER_W + 9;
  logic [G_W-1:0] w_gnum;
  logic [7:0]     w_grey;
  // Ramp is rounded to nearest so iteration 2 of 64 lands on 8'h08.
  assign w_gnum = G_W'(w_iter_sel) * G_W'(255) + G_W'(MAX_ITER / 2);
  assign w_grey = 8'(w_gnum / G_W'(MAX_ITER));

  always_comb begin
    w_rgb = '0;
    if (w_iter_sel != ITER_MAX) begin
      w_rgb = {3{w_grey}};
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_x_min    <= '0;
      r_step     <= '0;
      r_c_re     <= '0;
      r_c_im     <= '0;
      r_zr       <= '0;
      r_zi       <= '0;
      r_cnt      <= '0;
      r_x        <= '0;
      r_addr     <= '0;
      r_px_iter  <= '0;
      r_px_rgb   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_px_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_x_min <= Z_W'(x_min);
            r_step  <= Z_W'(step);
            r_c_re  <= Z_W'(x_min);
            r_c_im  <= Z_W'(y_min);
            r_x     <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_state <= StInit;
          end
        end
        StInit: begin
          r_zr    <= '0;
          r_zi    <= '0;
          r_cnt   <= '0;
          r_state <= StIter;
        end
        StIter: begin
          if (w_esc || (r_cnt == ITER_MAX)) begin
            r_px_iter  <= w_iter_sel;
            r_px_rgb   <= w_rgb;
            r_px_valid <= 1'b1;
            r_state    <= StEmit;
          end else begin
            r_zr  <= w_zr_nxt;
            r_zi  <= w_zi_nxt;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StEmit: begin
          if (px_ready) begin
            r_px_valid <= 1'b0;
            if (r_addr == LAST_ADDR) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= StDone;
            end else begin
              r_addr <= r_addr + 1'b1;
              // c tracks the pixel by accumulation rather than multiplication.
              if (r_x == X_LAST) begin
                r_x    <= '0;
                r_c_re <= r_x_min;
                r_c_im <= r_c_im + r_step;
              end else begin
                r_x    <= r_x + 1'b1;
                r_c_re <= r_c_re + r_step;
              end
              r_state <= StInit;
            end
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign px_valid = r_px_valid;
  assign px_addr  = r_addr;
  assign px_iter  = r_px_iter;
  assign px_rgb   = r_px_rgb;

endmodule

// File: tb/tb_mandelbrot_frame_engine.sv
// Randomised bench for mandelbrot_frame_engine on a 4x2 raster against an integer escape-time model.
module tb_mandelbrot_frame_engine;

  localparam int H = 4;
  localparam int V = 2;
  localparam int N = H * V;

  logic               clk = 1'b0;
  logic               reset, start, px_ready;
  logic signed [15:0] x_min, y_min, step;
  logic               busy, done, px_valid;
  logic [2:0]         px_addr;
  logic [6:0]         px_iter;
  logic [23:0]        px_rgb;

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] first_rgb;

  mandelbrot_frame_engine #(
    .H_ACTIVE(H),
    .V_ACTIVE(V)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .x_min   (x_min),
    .y_min   (y_min),
    .step    (step),
    .busy    (busy),
    .done    (done),
    .px_valid(px_valid),
    .px_ready(px_ready),
    .px_addr (px_addr),
    .px_iter (px_iter),
    .px_rgb  (px_rgb)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Plain integer escape-time iteration in Q.12.
  function automatic int model_iter(input longint cre, input longint cim);
    longint zr = 0;
    longint zi = 0;
    longint t;
    for (int n = 0; n <= 64; n++) begin
      if (zr * zr + zi * zi > (longint'(4) << 24)) return n;
      if (n == 64) return 64;
      t  = ((zr * zr - zi * zi) >>> 12) + cre;
      zi = ((2 * zr * zi) >>> 12) + cim;
      zr = t;
    end
    return 64;
  endfunction

  function automatic logic [23:0] model_rgb(input int it);
    int g;
    if (it == 64) return 24'h0;
`ifdef MANDEL_PALETTE_EN
    return {8'((it % 16) * 16), 8'(255 - (it % 16) * 16), 8'((it % 16) * 8)};
`else
    g = (it * 255 + 32) / 64;
    return {8'(g), 8'(g), 8'(g)};
`endif
  endfunction

  task automatic wait_valid(output bit ok);
    int k = 0;
    while (!px_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    ok = px_valid;
    if (!ok) check_eq("valid_timeout", 32'(px_valid), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_valid"}, 32'(px_valid), 32'd0);
    check_eq({tag, "_addr"}, 32'(px_addr), 32'd0);
    check_eq({tag, "_iter"}, 32'(px_iter), 32'd0);
    check_eq({tag, "_rgb"}, 32'(px_rgb), 32'd0);
  endtask

  task automatic run_frame(input int xm, input int ym, input int st, input int stall_lo,
                           input int stall_hi, input bit poke_start, input int abort_at);
    bit ok;
    int exp_it, stall;
    logic [23:0] exp_rgb;
    x_min = 16'(xm);
    y_min = 16'(ym);
    step  = 16'(st);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    x_min = 16'($urandom);
    y_min = 16'($urandom);
    step  = 16'($urandom);
    @(negedge clk);
    for (int a = 0; a < N; a++) begin
      wait_valid(ok);
      if (!ok) return;
      if (a == abort_at) begin
        #2 reset = 1'b0;
        #1 check_idle_outputs("abort");
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      exp_it  = model_iter(longint'(xm) + (a % H) * st, longint'(ym) + (a / H) * st);
      exp_rgb = model_rgb(exp_it);
      if (a == 0) first_rgb = px_rgb;
      check_eq("addr", 32'(px_addr), 32'(a));
      check_eq("iter", 32'(px_iter), 32'(exp_it));
      check_eq("rgb", 32'(px_rgb), 32'(exp_rgb));
      check_eq("busy_mid", 32'(busy), 32'd1);
      if (poke_start && a == 1) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
      end
      stall = $urandom_range(stall_lo, stall_hi);
      repeat (stall) begin
        @(negedge clk);
        check_eq("hold_valid", 32'(px_valid), 32'd1);
        check_eq("hold_addr", 32'(px_addr), 32'(a));
        check_eq("hold_data", {1'b0, px_iter, px_rgb}, {1'b0, 7'(exp_it), exp_rgb});
      end
      px_ready = 1'b1;
      @(posedge clk);
      #1 px_ready = 1'b0;
      @(negedge clk);
      if (a == N - 1) begin
        check_eq("done_last", 32'(done), 32'd1);
        check_eq("busy_last", 32'(busy), 32'd0);
        check_eq("valid_last", 32'(px_valid), 32'd0);
      end else begin
        check_eq("done_early", 32'(done), 32'd0);
      end
    end
    // A start in the done cycle must not launch a new frame.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_valid", 32'(px_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    reset    = 1'b0;
    start    = 1'b1;
    px_ready = 1'b0;
    x_min    = '0;
    y_min    = '0;
    step     = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_eq("post_reset_busy", 32'(busy), 32'd0);

    // c = 0: in-set pixel, valid 66 cycles after the accepting edge.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!px_valid && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    check_eq("c0_latency", 32'(cyc), 32'd66);
    check_eq("c0_iter", 32'(px_iter), 32'd64);
    check_eq("c0_rgb", 32'(px_rgb), 32'd0);
    check_eq("c0_addr", 32'(px_addr), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_idle_outputs("c0_abort");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // c = 2.0 everywhere: every pixel escapes at count 2.
    run_frame(16'sh2000, 0, 0, 0, 0, 1'b0, -1);
`ifdef MANDEL_PALETTE_EN
    check_eq("rgb_iter2", 32'(first_rgb), 32'h20DF10);
`else
    check_eq("rgb_iter2", 32'(first_rgb), 32'h080808);
`endif

    // Backpressure: five stall cycles on every pixel.
    run_frame(int'($urandom_range(0, 14336)) - 10240, int'($urandom_range(0, 12288)) - 6144,
              int'($urandom_range(0, 1228)) - 614, 5, 5, 1'b0, -1);

    // Abort at pixel 3, then a fresh frame must restart at address 0.
    run_frame(int'($urandom_range(0, 14336)) - 10240, int'($urandom_range(0, 12288)) - 6144,
              int'($urandom_range(0, 1228)) - 614, 0, 2, 1'b0, 3);
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      run_frame(int'($urandom_range(0, 14336)) - 10240, int'($urandom_range(0, 12288)) - 6144,
                int'($urandom_range(0, 1228)) - 614, 0, 3, 1'b1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
